pwm_cmd_sequencer: RTL and testbench

Command sequencer upstream of the pattern PWM generator. Buffers PWM jobs (pattern, duty, interval, pulse count) in a small FIFO, holds each job's parameters stable for the whole run, and drives the generator's enable. Finite jobs complete on their own. Infinite jobs end on a stop request or, optionally, when a newer job is queued. It reports completion per job, keeps a done count, and flags generators that never start.

---
 rtl/pwm_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_pwm_cmd_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cmd_sequencer.sv
// Command sequencer for the pattern PWM generator: queues jobs, holds their parameters, drives pwm_en.
// Optional PWM_SEQ_PREEMPT_EN: a queued job ends a running infinite job.
module pwm_cmd_sequencer #(
  parameter int _PAT_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ARM_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_duty,
  input  logic [15:0]                   cmd_dessert,
  input  logic [7:0]                    cmd_pulse_num,
  input  logic [_PAT_WIDTH-1:0]         cmd_pat,
  input  logic                          stop_req,
  output logic                          pwm_en,
  output logic [7:0]                    duty_num,
  output logic [15:0]                   pulse_dessert,
  output logic [7:0]                    pulse_num,
  output logic [_PAT_WIDTH-1:0]         PAT,
  input  logic                          pwm_busy,
  output logic                          seq_busy,
  output logic                          cmd_done,
  output logic [15:0]                   done_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 8 + 16 + 8 + _PAT_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty, push, pop;

  state_t        state, state_nxt;
  logic          pwm_en_nxt, err_set, arm_expired, run_stop;
  logic [7:0]    arm_cnt;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full && !stop_req;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_LOAD);
  assign fifo_level = count;

  // stop_req wins over everything: a same-cycle pop in LOAD still reads the head first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (stop_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_duty, cmd_dessert, cmd_pulse_num, cmd_pat};
  end

  // arm_cnt holds completed ARM cycles, so +1 counts the current one.
  assign arm_expired = (({1'b0, arm_cnt} + 9'd1) == 9'(ARM_TIMEOUT));

`ifdef PWM_SEQ_PREEMPT_EN
  assign run_stop = stop_req || !fifo_empty;
`else
  assign run_stop = stop_req;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    pwm_en_nxt = pwm_en;
    err_set    = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty && !stop_req) state_nxt = S_LOAD;
      S_LOAD: begin
        pwm_en_nxt = 1'b1;
        state_nxt  = S_ARM;
      end
      S_ARM: begin
        if (pwm_busy) begin
          state_nxt = S_RUN;
          if (pulse_num != 8'd0) pwm_en_nxt = 1'b0;
        end else if (arm_expired) begin
          err_set    = 1'b1;
          pwm_en_nxt = 1'b0;
          state_nxt  = S_IDLE;
        end
      end
      S_RUN: begin
        if (pulse_num == 8'd0 && run_stop) pwm_en_nxt = 1'b0;
        if (!pwm_busy) begin
          pwm_en_nxt = 1'b0;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        pwm_en_nxt = 1'b0;
        state_nxt  = S_IDLE;
      end
      default: begin
        pwm_en_nxt = 1'b0;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pwm_en        <= 1'b0;
      err_timeout   <= 1'b0;
      done_count    <= '0;
      arm_cnt       <= '0;
      duty_num      <= '0;
      pulse_dessert <= '0;
      pulse_num     <= '0;
      PAT           <= '0;
    end else begin
      state  <= state_nxt;
      pwm_en <= pwm_en_nxt;
      if (err_set) err_timeout <= 1'b1;
      if (state == S_DONE) done_count <= done_count + 16'd1;
      if (state == S_LOAD) begin
        arm_cnt <= '0;
        {duty_num, pulse_dessert, pulse_num, PAT} <= mem[rd_ptr];
      end else if (state == S_ARM) begin
        arm_cnt <= arm_cnt + 8'd1;
      end
    end
  end

  assign cmd_done = (state == S_DONE);
  assign seq_busy = (state != S_IDLE);

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Bench for pwm_cmd_sequencer: directed scenarios plus random traffic against a job-level reference model.
// A behavioural generator drives pwm_busy; build with PWM_SEQ_PREEMPT_EN to match a preempting DUT.
module tb_pwm_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int ARM_TO = 10;
`ifdef PWM_SEQ_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  duty;
    logic [15:0] dessert;
    logic [7:0]  num;
    logic [7:0]  pat;
  } job_t;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_duty, cmd_pulse_num, cmd_pat;
  logic [15:0] cmd_dessert;
  logic        stop_req, pwm_en, pwm_busy, seq_busy, cmd_done, err_timeout;
  logic [7:0]  duty_num, pulse_num, PAT;
  logic [15:0] pulse_dessert, done_count;
  logic [2:0]  fifo_level;

  pwm_cmd_sequencer #(._PAT_WIDTH(8), .FIFO_DEPTH(DEPTH), .ARM_TIMEOUT(ARM_TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty), .cmd_dessert(cmd_dessert), .cmd_pulse_num(cmd_pulse_num),
    .cmd_pat(cmd_pat), .stop_req(stop_req), .pwm_en(pwm_en), .duty_num(duty_num),
    .pulse_dessert(pulse_dessert), .pulse_num(pulse_num), .PAT(PAT), .pwm_busy(pwm_busy),
    .seq_busy(seq_busy), .cmd_done(cmd_done), .done_count(done_count),
    .fifo_level(fifo_level), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: job queue plus the life cycle of the job currently owning the generator.
  job_t mq[$];
  job_t cur;
  bit   job_active, running, done_now, exp_err;
  int   arm_cycles, exp_dc, n_to, low_run;
  logic en_prev;

  // Behavioural generator: starts 0..3 cycles after enable; finite runs last a random time.
  bit   gen_dead;
  int   g_delay, g_left;

  task automatic model_reset();
    mq.delete();
    job_active = 0; running = 0; done_now = 0; exp_err = 0;
    arm_cycles = 0; exp_dc = 0; low_run = 2; en_prev = 1'b0;
    g_delay = -1; g_left = 0; pwm_busy = 1'b0;
  endtask

  function automatic bit model_idle();
    return !job_active && mq.size() == 0 && !done_now;
  endfunction

  // Called at each falling edge; inputs still hold the values the preceding rising edge saw.
  task automatic observe();
    int   pre;
    bit   acc, rose, act0;
    job_t got;
    got  = '{duty: duty_num, dessert: pulse_dessert, num: pulse_num, pat: PAT};
    pre  = mq.size();
    acc  = cmd_valid && (pre < DEPTH) && !stop_req;
    rose = pwm_en && !en_prev;
    if (done_now) exp_dc++;
    done_now = 1'b0;
    act0 = job_active;
    if (act0 && !running) begin
      if (pwm_busy) begin
        running = 1'b1;
        check("en_after_busy", pwm_en, cur.num == 8'd0);
      end else begin
        arm_cycles++;
        if (arm_cycles == ARM_TO) begin
          exp_err = 1'b1;
          job_active = 1'b0;
          n_to++;
          check("en_timeout", pwm_en, 0);
        end else begin
          check("en_arming", pwm_en, 1);
        end
      end
    end else if (act0) begin
      if (!pwm_busy) begin
        job_active = 1'b0;
        done_now = 1'b1;
        check("en_done", pwm_en, 0);
      end else if (cur.num == 8'd0) begin
        check("en_infinite", pwm_en, en_prev && !(stop_req || (PREEMPT && pre != 0)));
      end else begin
        check("en_finite", pwm_en, 0);
      end
    end
    if (rose) begin
      check("load_while_active", act0, 0);
      check("en_gap", low_run >= 2, 1);
      check("pop_nonempty", mq.size() != 0, 1);
      if (mq.size() != 0) cur = mq.pop_front();
      job_active = 1'b1;
      running = 1'b0;
      arm_cycles = 0;
    end else if (!act0) begin
      check("en_idle", pwm_en, 0);
    end
    if (job_active || done_now) begin
      check("params", got, cur);
      check("seq_busy", seq_busy, 1);
    end
    check("cmd_done", cmd_done, done_now);
    if (acc) mq.push_back('{cmd_duty, cmd_dessert, cmd_pulse_num, cmd_pat});
    if (stop_req) mq.delete();
    check("fifo_level", fifo_level, mq.size());
    check("cmd_ready", cmd_ready, (mq.size() < DEPTH) && !stop_req);
    check("done_count", done_count, exp_dc[15:0]);
    check("err_timeout", err_timeout, exp_err);
    low_run = pwm_en ? 0 : low_run + 1;
    en_prev = pwm_en;
  endtask

  task automatic gen_step();
    if (gen_dead) begin
      pwm_busy = 1'b0;
      g_delay = -1;
    end else if (!pwm_busy) begin
      if (pwm_en) begin
        if (g_delay < 0) g_delay = $urandom_range(0, 3);
        if (g_delay == 0) begin
          pwm_busy = 1'b1;
          g_left = (pulse_num == 8'd0) ? -1 : int'($urandom_range(1, 3 * pulse_num));
          g_delay = -1;
        end else begin
          g_delay--;
        end
      end else begin
        g_delay = -1;
      end
    end else if (g_left < 0) begin
      if (!pwm_en) pwm_busy = 1'b0;
    end else begin
      g_left--;
      if (g_left == 0) pwm_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    gen_step();
  endtask

  task automatic push_job(input job_t j);
    cmd_valid = 1'b1;
    {cmd_duty, cmd_dessert, cmd_pulse_num, cmd_pat} = j;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      stop_req = 1'b0;
      if (job_active && running && cur.num == 8'd0 && (n % 16) == 15) stop_req = 1'b1;
      cycle();
      n++;
    end
    stop_req = 1'b0;
    check(tag, n < budget, 1);
  endtask

  task automatic wait_running(input string tag, input int budget);
    int n = 0;
    while (!(job_active && running) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc0, to0, acc_n, n;
    bit   will_acc;
    job_t j;

    cmd_valid = 0; cmd_duty = 0; cmd_dessert = 0; cmd_pulse_num = 0; cmd_pat = 0;
    stop_req = 0; gen_dead = 0; n_to = 0;
    model_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_pwm_en", pwm_en, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_params", {duty_num, pulse_dessert, pulse_num, PAT}, 0);
    check("rst_done_count", done_count, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_ready", cmd_ready, 1);
    stop_req = 1'b1;
    #1 check("rst_ready_stop", cmd_ready, 0);
    stop_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cycle();

    // Single finite job: enable two edges after acceptance, parameters held to DONE.
    push_job('{8'd2, 16'd5, 8'd3, 8'h0D});
    cycle();
    cycle();
    check("latency_en", pwm_en, 1);
    run_until_idle("finite_bound", 200);
    check("finite_done_count", done_count, 16'd1);

    // Back-to-back: keep pushing until five are accepted, which fills the FIFO.
    dc0 = exp_dc;
    acc_n = 0;
    n = 0;
    while (acc_n < 5 && n < 60) begin
      j = '{8'(acc_n + 1), 16'($urandom), 8'($urandom_range(4, 8)), 8'($urandom)};
      will_acc = (mq.size() < DEPTH) && !stop_req;
      push_job(j);
      if (will_acc) acc_n++;
      n++;
    end
    check("b2b_push_bound", n < 60, 1);
    check("b2b_full_level", fifo_level, 3'd4);
    check("b2b_full_ready", cmd_ready, 0);
    push_job('{8'hEE, 16'hEEEE, 8'd1, 8'hEE});
    check("b2b_blocked_level", fifo_level, 3'd4);
    run_until_idle("b2b_bound", 1000);
    check("b2b_done_count", done_count, 16'(dc0 + 5));

    // Infinite job ended by a one-cycle stop request.
    dc0 = exp_dc;
    push_job('{8'd7, 16'd100, 8'd0, 8'hA5});
    repeat (100) cycle();
    stop_req = 1'b1;
    cycle();
    stop_req = 1'b0;
    check("stop_en_low", pwm_en, 0);
    check("stop_flush", fifo_level, 0);
    run_until_idle("stop_bound", 100);
    check("stop_done_count", done_count, 16'(dc0 + 1));

    // A finite job queued behind a running infinite job.
    dc0 = exp_dc;
    push_job('{8'd9, 16'd40, 8'd0, 8'h5A});
    repeat (30) cycle();
    push_job('{8'd4, 16'd12, 8'd2, 8'h33});
`ifdef PWM_SEQ_PREEMPT_EN
    run_until_idle("preempt_bound", 300);
    check("preempt_done_count", done_count, 16'(dc0 + 2));
`else
    repeat (20) cycle();
    check("nopreempt_en", pwm_en, 1);
    check("nopreempt_level", fifo_level, 3'd1);
    stop_req = 1'b1;
    cycle();
    stop_req = 1'b0;
    check("nopreempt_flush", fifo_level, 0);
    run_until_idle("nopreempt_bound", 100);
    check("nopreempt_done_count", done_count, 16'(dc0 + 1));
`endif

    // Random traffic: pushes, occasional stops, some infinite jobs.
    for (int i = 0; i < 400; i++) begin
      cmd_valid     = ($urandom_range(0, 3) == 0);
      cmd_duty      = 8'($urandom);
      cmd_dessert   = 16'($urandom);
      cmd_pulse_num = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      cmd_pat       = 8'($urandom);
      stop_req      = ($urandom_range(0, 29) == 0);
      cycle();
    end
    cmd_valid = 1'b0;
    stop_req  = 1'b0;
    run_until_idle("random_drain_bound", 3000);

    // Generator never starts: both queued jobs time out, no completions counted.
    dc0 = exp_dc;
    to0 = n_to;
    gen_dead = 1'b1;
    push_job('{8'd1, 16'd1, 8'd1, 8'h11});
    push_job('{8'd2, 16'd2, 8'd2, 8'h22});
    n = 0;
    while (n_to < to0 + 2 && n < 200) begin
      cycle();
      n++;
    end
    check("timeout_bound", n < 200, 1);
    check("timeout_err", err_timeout, 1);
    check("timeout_en", pwm_en, 0);
    check("timeout_done_count", done_count, 16'(dc0));
    repeat (3) cycle();
    gen_dead = 1'b0;

    // Asynchronous reset in the middle of an infinite run with one job queued.
    push_job('{8'd3, 16'd9, 8'd0, 8'h3C});
    wait_running("reset_run_bound", 50);
    push_job('{8'd1, 16'd2, 8'd1, 8'h01});
    #3 rst = 1'b1;
    #1;
    check("async_rst_pwm_en", pwm_en, 0);
    check("async_rst_seq_busy", seq_busy, 0);
    check("async_rst_fifo_level", fifo_level, 0);
    check("async_rst_done_count", done_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle();
    check("post_rst_err", err_timeout, 0);
    check("post_rst_params", {duty_num, pulse_dessert, pulse_num, PAT}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
